parity_frame_ctrl: RTL
======================

Name: parity_frame_ctrl

Overview:
- Serial frame receiver and controller that sequences the 4-bit-plus-parity check datapath.
- Frame format: start bit (0), DATA_W data bits LSB-first, one parity bit, stop bit (1). Bits are sampled on a bit-strobe enable.
- Presents each checked word and its parity-error flag on a valid/ready output handshake.
- Keeps a saturating count of parity-error frames for the status display.

Parameters:
- DATA_W, 4: number of data bits per frame.
- CNT_W, 8: width of the parity-error counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- sin  input  1  serial data line; idle level 1.
- en  input  1  bit strobe; sin is sampled only in cycles with en=1.
- out_ready  input  1  consumer accepts the output word.
- out_valid  output  1  out_data/out_pec hold a completed frame.
- out_data  output  DATA_W  received data; bit i = i-th data bit received.
- out_pec  output  1  parity error flag; 1 = frame failed the check.
- err_cnt  output  CNT_W  number of accepted frames with out_pec=1; saturating.
- busy  output  1  1 in any state other than IDLE.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; sampled at the clk edge; overrides everything.
- Reset values: state=IDLE; bit index=0; shift register=0; out_valid=0; out_data=0; out_pec=0; err_cnt=0; busy=0; frame_err=0.
- Reset mid-frame: the partial frame is discarded, nothing is output, err_cnt is cleared.
- FSM states: IDLE, DATA, PAR, STOP, HOLD. All transitions out of IDLE, DATA, PAR and STOP happen only in cycles with en=1.
- IDLE: en=1 and sin=0 → DATA, bit index cleared. en=1 and sin=1 → stay.
- DATA: each en=1 shifts sin into the register LSB-first and increments the bit index. On the DATA_W-th bit → PAR.
- PAR: en=1 captures sin as parity bit p → STOP.
- STOP, sin=1: → HOLD. The next cycle has out_valid=1, out_data=shift register, and out_pec = XOR of all data bits XOR p (even parity; 0 = good).
- STOP, sin=0: frame_err=1 for exactly the next cycle → IDLE. No output, err_cnt unchanged.
- HOLD: out_valid stays 1 and out_data/out_pec stay stable until out_valid & out_ready.
- Handshake cycle: → IDLE; out_valid=0 from the next cycle.
- en/sin activity during HOLD is ignored. There is no buffering; bits arriving then are dropped.
- err_cnt: increments by 1 in the handshake cycle when out_pec=1. It saturates at 2^CNT_W−1 and never wraps.
- out_ready while out_valid=0 has no effect.
- Latency: out_valid rises 1 clk after the stop-bit strobe.
- out_data/out_pec hold their last values after the handshake until the next frame completes.
- busy is a registered decode of state != IDLE.

Optional Feature:
- Macro: ODD_PARITY_EN.
- Defined: odd parity; out_pec = ~(XOR of data bits XOR p).
- Undefined: even parity as above.
- Everything else is identical.

Test Plan:
- Reset, then sin=1 with 20 en pulses → out_valid=0, busy=0, frame_err=0, err_cnt=0.
- Frame: start 0; data 1,1,0,1; p=1; stop 1; out_ready=1 → out_valid=1 one cycle after the stop strobe, out_data=4'hB, out_pec=0; err_cnt stays 0.
- Same frame with p=0 → out_pec=1; after the handshake err_cnt=1. Send a second bad frame → err_cnt=2.
- Frame with stop bit 0 → frame_err high for exactly 1 cycle; out_valid never asserts; state returns to IDLE; err_cnt unchanged.
- Backpressure and reset:
  - Complete a frame with out_ready=0 for 10 cycles while sin toggles under en → out_valid stays 1 and out_data/out_pec stay stable.
  - Raise out_ready for 1 cycle → out_valid=0 next cycle.
  - Assert rst after 2 data bits of a new frame → busy=0 next cycle and no output.
- CNT_W=2, five bad frames accepted → err_cnt goes 1,2,3,3,3. With ODD_PARITY_EN defined, data 4'hB and p=0 → out_pec=0.

Source files
------------

// File: rtl/parity_frame_ctrl_if.sv
// parity_frame_ctrl_if: valid/ready output bundle of the frame receiver.
// master drives the checked word, slave drives out_ready.
interface parity_frame_ctrl_if #(
    parameter int DATA_W = 4
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_pec;

    modport master (
        output out_valid,
        output out_data,
        output out_pec,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_pec,
        output out_ready
    );
endinterface

// File: rtl/parity_frame_ctrl.sv
// parity_frame_ctrl: serial frame receiver with parity check and valid/ready output.
// Build with ODD_PARITY_EN defined for odd parity; even parity otherwise.
module parity_frame_ctrl #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sin,
    input  logic                en,
    parity_frame_ctrl_if.master bus,
    output logic [CNT_W-1:0]    err_cnt,
    output logic                busy,
    output logic                frame_err
);

    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PAR,
        STOP,
        HOLD
    } state_t;

    state_t            state;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] shreg;
    logic              par;
    logic              pec;

`ifdef ODD_PARITY_EN
    assign pec = ~(^shreg ^ par);
`else
    assign pec = ^shreg ^ par;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            shreg         <= '0;
            par           <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_pec   <= 1'b0;
            err_cnt       <= '0;
            busy          <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en && !sin) begin
                        state <= DATA;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                DATA: begin
                    if (en) begin
                        // LSB-first: each new bit enters at the top
                        shreg <= (shreg >> 1)
                               | (DATA_W'(sin) << (DATA_W - 1));
                        idx   <= idx + IW'(1);
                        if (idx == IW'(DATA_W - 1)) begin
                            state <= PAR;
                        end
                    end
                end
                PAR: begin
                    if (en) begin
                        par   <= sin;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (en) begin
                        if (sin) begin
                            state         <= HOLD;
                            bus.out_valid <= 1'b1;
                            bus.out_data  <= shreg;
                            bus.out_pec   <= pec;
                        end else begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            frame_err <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        busy          <= 1'b0;
                        bus.out_valid <= 1'b0;
                        if (bus.out_pec && (err_cnt != '1)) begin
                            err_cnt <= err_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
